// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the writeback stage: load width codes,
// WB state encoding and the MEM/WB pipeline bundle.
package rv32i_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_WAIT_LOAD = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] result;
        logic        is_load;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
    } mem_wb_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data alignment: selects the addressed byte/half of the raw memory
// word and sign- or zero-extends it to 32 bits according to funct3.
import rv32i_pkg::*;

module load_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        value = rdata;
        case (funct3)
            F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   value = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  value = {24'd0, byte_sel};
            F3_LHU:  value = {16'd0, half_sel};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: MEM/WB register, load-response wait FSM, register
// file write port and retired-instruction counter.
import rv32i_pkg::*;

module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [4:0]  mem_rd_i,
    input  logic        mem_wen_i,
    input  logic [31:0] mem_result_i,
    input  logic        mem_is_load_i,
    input  logic [2:0]  mem_funct3_i,
    input  logic [1:0]  mem_addr_lo_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic [4:0]  reg_addr_o,
    output logic [31:0] reg_data_o,
    output logic        reg_wen_o,
    output logic [63:0] instret_o
);

    wb_state_e   state_q, state_d;
    mem_wb_t     wb_q, wb_d;
    logic [63:0] instret_q;
    logic [31:0] load_value;
    logic        busy, commit, stall;

    load_align u_load_align (
        .funct3  (wb_q.funct3),
        .addr_lo (wb_q.addr_lo),
        .rdata   (dmem_rdata_i),
        .value   (load_value)
    );

    assign busy   = (state_q != ST_IDLE);
    assign stall  = busy && wb_q.is_load && !dmem_rvalid_i;
    assign commit = busy && (!wb_q.is_load || dmem_rvalid_i);

    assign wb_d = '{rd: mem_rd_i, wen: mem_wen_i, result: mem_result_i,
                    is_load: mem_is_load_i, funct3: mem_funct3_i,
                    addr_lo: mem_addr_lo_i};

    always_comb begin
        state_d = state_q;
        if (stall)
            state_d = ST_WAIT_LOAD;
        else
            state_d = mem_valid_i ? ST_ACTIVE : ST_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            wb_q      <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (!stall)
                wb_q <= wb_d;
            if (commit)
                instret_q <= instret_q + 64'd1;
        end
    end

    // Outputs are gated by occupancy so a stale WB register never leaks out.
    assign stall_o    = stall;
    assign reg_wen_o  = commit && wb_q.wen && (wb_q.rd != 5'd0);
    assign reg_addr_o = busy ? wb_q.rd : 5'd0;
    assign reg_data_o = !busy ? 32'd0 : (wb_q.is_load ? load_value : wb_q.result);
    assign instret_o  = instret_q;

endmodule
